// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector:
// mode select encodings, detector state codes and the length-width helper.
package seq_det_pkg;

    localparam logic [0:0] OVL_OFF    = 1'b0;
    localparam logic [0:0] OVL_ON     = 1'b1;

    localparam logic [0:0] OUT_MEALY  = 1'b0;
    localparam logic [0:0] OUT_MOORE  = 1'b1;

    localparam logic [0:0] ST_FILLING = 1'b0;
    localparam logic [0:0] ST_ARMED   = 1'b1;

    // Bits needed to hold a length value 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), clr (sync clear), inc (count enable), q (value).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_seq_detector.sv
// Programmable serial pattern detector with overlap and Mealy/Moore select.
// Ports: clk, rst (async high), ain/in_valid (serial input), cfg_load plus
// cfg_pattern/cfg_len/cfg_overlap/cfg_moore (config latch), aout (match),
// match_count (saturating matches since reset or last cfg_load).
module prog_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ain,
    input  logic                       in_valid,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cfg_moore,
    output logic                       aout,
    output logic [CNT_W-1:0]           match_count
);

    localparam int              LEN_W  = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    logic               r_overlap;
    logic               r_moore;
    logic               r_aout_q;

    logic [LEN_W-1:0]   w_len_clamped;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_p1;
    logic [0:0]         w_state;
    logic               w_accept;
    logic               w_enabled;
    logic               w_match;

    assign w_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // A load cycle swallows the incoming bit.
    assign w_accept  = in_valid & ~cfg_load;
    assign w_enabled = (r_len != '0);

    // Newest bit sits at [0]; the window includes the bit being presented.
    assign w_window  = {r_hist[MAX_LEN-2:0], ain};
    assign w_fill_p1 = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_state   = (w_fill_p1 >= {1'b0, r_len}) ? ST_ARMED : ST_FILLING;

    // Only the low len bits take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_accept & w_enabled & (w_state == ST_ARMED)
                   & ((w_window & w_mask) == (r_pattern & w_mask));

    assign aout = ~rst & ((r_moore == OUT_MOORE) ? r_aout_q : w_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_aout_q  <= 1'b0;
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= OVL_ON;
            r_moore   <= OUT_MEALY;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_moore   <= cfg_moore;
            r_fill    <= '0;
            r_aout_q  <= 1'b0;
        end else begin
            r_aout_q <= w_match;
            if (in_valid) begin
                r_hist <= w_window;
                // Non-overlap restarts the fill so the next hit needs fresh bits.
                if (w_match && (r_overlap == OVL_OFF)) begin
                    r_fill <= '0;
                end else if (r_fill < LEN_MAX) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (w_match),
        .q   (match_count)
    );

endmodule

// File: tb/tb_prog_seq_detector.sv
// Directed table-driven bench for prog_seq_detector, plus hand sequences
// for async reset mid-match and a 2-bit saturating counter instance.
module tb_prog_seq_detector;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        string      g;
        logic       ain;
        logic       iv;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       moore;
        logic       exp_a;
        logic [7:0] exp_c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ain, in_valid, cfg_load, cfg_overlap, cfg_moore;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       aout;
    logic [7:0] match_count;

    logic       ain2, iv2, ld2, ovl2, moore2;
    logic [7:0] pat2;
    logic [3:0] len2;
    logic       aout2;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    prog_seq_detector dut (
        .clk         (clk),
        .rst         (rst),
        .ain         (ain),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .aout        (aout),
        .match_count (match_count)
    );

    prog_seq_detector #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .ain         (ain2),
        .in_valid    (iv2),
        .cfg_load    (ld2),
        .cfg_pattern (pat2),
        .cfg_len     (len2),
        .cfg_overlap (ovl2),
        .cfg_moore   (moore2),
        .aout        (aout2),
        .match_count (cnt2)
    );

    function automatic vec_t b(input string g, input logic a, iv,
                               input logic ea, input logic [7:0] ec);
        vec_t v;
        v.g = g; v.ain = a; v.iv = iv; v.ld = L;
        v.pat = 8'd0; v.len = 4'd0; v.ovl = L; v.moore = L;
        v.exp_a = ea; v.exp_c = ec;
        return v;
    endfunction

    function automatic vec_t ld(input string g, input logic [7:0] p,
                                input logic [3:0] l, input logic o, m,
                                input logic a, iv);
        vec_t v;
        v.g = g; v.ain = a; v.iv = iv; v.ld = H;
        v.pat = p; v.len = l; v.ovl = o; v.moore = m;
        v.exp_a = L; v.exp_c = 8'd0;
        return v;
    endfunction

    task automatic chk(input string n, input logic [7:0] got, exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        ain         = v.ain;
        in_valid    = v.iv;
        cfg_load    = v.ld;
        cfg_pattern = v.pat;
        cfg_len     = v.len;
        cfg_overlap = v.ovl;
        cfg_moore   = v.moore;
        #1 chk($sformatf("%s%0d aout", v.g, idx), {7'd0, aout}, {7'd0, v.exp_a});
        @(posedge clk);
        #1 chk($sformatf("%s%0d count", v.g, idx), match_count, v.exp_c);
    endtask

    initial begin
        // A: reset defaults, pattern 1011, overlap, Mealy
        vq.push_back(b("A", H, H, L, 8'd0));
        vq.push_back(b("A", L, H, L, 8'd0));
        vq.push_back(b("A", H, H, L, 8'd0));
        vq.push_back(b("A", H, H, H, 8'd1));
        vq.push_back(b("A", L, H, L, 8'd1));
        vq.push_back(b("A", H, H, L, 8'd1));
        vq.push_back(b("A", H, H, H, 8'd2));
        // B: 1010 overlap, load cycle carries a bit that must be dropped
        vq.push_back(ld("B", 8'b0000_1010, 4'd4, H, L, H, H));
        vq.push_back(b("B", H, H, L, 8'd0));
        vq.push_back(b("B", L, H, L, 8'd0));
        vq.push_back(b("B", H, H, L, 8'd0));
        vq.push_back(b("B", L, H, H, 8'd1));
        vq.push_back(b("B", H, H, L, 8'd1));
        vq.push_back(b("B", L, H, H, 8'd2));
        vq.push_back(b("B", H, H, L, 8'd2));
        vq.push_back(b("B", L, H, H, 8'd3));
        // C: 1010 non-overlap
        vq.push_back(ld("C", 8'b0000_1010, 4'd4, L, L, L, L));
        vq.push_back(b("C", H, H, L, 8'd0));
        vq.push_back(b("C", L, H, L, 8'd0));
        vq.push_back(b("C", H, H, L, 8'd0));
        vq.push_back(b("C", L, H, H, 8'd1));
        vq.push_back(b("C", H, H, L, 8'd1));
        vq.push_back(b("C", L, H, L, 8'd1));
        vq.push_back(b("C", H, H, L, 8'd1));
        vq.push_back(b("C", L, H, H, 8'd2));
        // D: 1011 Moore, gaps mid-pattern
        vq.push_back(ld("D", 8'b0000_1011, 4'd4, H, H, L, L));
        vq.push_back(b("D", H, H, L, 8'd0));
        vq.push_back(b("D", L, H, L, 8'd0));
        vq.push_back(b("D", H, L, L, 8'd0));
        vq.push_back(b("D", H, H, L, 8'd0));
        vq.push_back(b("D", H, H, L, 8'd1));
        vq.push_back(b("D", L, L, H, 8'd1));
        vq.push_back(b("D", L, L, L, 8'd1));
        vq.push_back(b("D", L, H, L, 8'd1));
        vq.push_back(b("D", H, H, L, 8'd1));
        vq.push_back(b("D", H, H, L, 8'd2));
        vq.push_back(b("D", L, H, H, 8'd2));
        vq.push_back(b("D", L, L, L, 8'd2));
        // E: reload mid-stream with a bit that would have completed 1011
        vq.push_back(ld("E", 8'b0000_1011, 4'd4, H, L, L, L));
        vq.push_back(b("E", H, H, L, 8'd0));
        vq.push_back(b("E", L, H, L, 8'd0));
        vq.push_back(b("E", H, H, L, 8'd0));
        vq.push_back(b("E", H, H, H, 8'd1));
        vq.push_back(b("E", L, H, L, 8'd1));
        vq.push_back(b("E", H, H, L, 8'd1));
        vq.push_back(ld("E", 8'b0000_1011, 4'd4, H, L, H, H));
        vq.push_back(b("E", H, H, L, 8'd0));
        vq.push_back(b("E", L, H, L, 8'd0));
        vq.push_back(b("E", H, H, L, 8'd0));
        vq.push_back(b("E", H, H, H, 8'd1));
        // F: len 0 disables detection
        vq.push_back(ld("F", 8'b0000_1011, 4'd0, H, L, L, L));
        vq.push_back(b("F", H, H, L, 8'd0));
        vq.push_back(b("F", L, H, L, 8'd0));
        vq.push_back(b("F", H, H, L, 8'd0));
        vq.push_back(b("F", H, H, L, 8'd0));
        vq.push_back(b("F", L, H, L, 8'd0));
        // G: len 15 clamps to 8
        vq.push_back(ld("G", 8'b1100_1010, 4'd15, H, L, L, L));
        vq.push_back(b("G", H, H, L, 8'd0));
        vq.push_back(b("G", H, H, L, 8'd0));
        vq.push_back(b("G", L, H, L, 8'd0));
        vq.push_back(b("G", L, H, L, 8'd0));
        vq.push_back(b("G", H, H, L, 8'd0));
        vq.push_back(b("G", L, H, L, 8'd0));
        vq.push_back(b("G", H, H, L, 8'd0));
        vq.push_back(b("G", L, H, H, 8'd1));
        vq.push_back(b("G", H, H, L, 8'd1));
        // H: pattern bits above len ignored (len 3 -> 101)
        vq.push_back(ld("H", 8'b1111_0101, 4'd3, H, L, L, L));
        vq.push_back(b("H", H, H, L, 8'd0));
        vq.push_back(b("H", L, H, L, 8'd0));
        vq.push_back(b("H", H, H, H, 8'd1));
        vq.push_back(b("H", L, H, L, 8'd1));
        vq.push_back(b("H", H, H, H, 8'd2));

        rst = H; ain = H; in_valid = H; cfg_load = L;
        cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = L; cfg_moore = L;
        ain2 = L; iv2 = L; ld2 = L; pat2 = 8'd0; len2 = 4'd0;
        ovl2 = L; moore2 = L;

        repeat (2) @(posedge clk);
        #1;
        chk("reset aout", {7'd0, aout}, 8'd0);
        chk("reset count", match_count, 8'd0);
        @(negedge clk);
        rst = L;

        foreach (vq[i]) apply(vq[i], i);

        // Async reset while a 1011 match is being presented
        @(negedge clk);
        cfg_load = L; in_valid = L;
        rst = H;
        @(negedge clk);
        rst = L;
        apply(b("R", H, H, L, 8'd0), 0);
        apply(b("R", L, H, L, 8'd0), 1);
        apply(b("R", H, H, L, 8'd0), 2);
        @(negedge clk);
        ain = H; in_valid = H; cfg_load = L;
        #1 chk("R pre-reset aout", {7'd0, aout}, 8'd1);
        #1 rst = H;
        #1 chk("R in-reset aout", {7'd0, aout}, 8'd0);
        chk("R in-reset count", match_count, 8'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = L;
        rst = L;
        apply(b("R", H, H, L, 8'd0), 3);
        apply(b("R", L, H, L, 8'd0), 4);
        apply(b("R", H, H, L, 8'd0), 5);
        apply(b("R", H, H, H, 8'd1), 6);

        // 2-bit counter: stream 1011011011011011 gives five overlapping hits
        begin
            int hits;
            logic exp_hit;
            hits = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                ain2 = (i >= 1 && (i - 1) % 3 == 0) ? L : H;
                iv2  = H;
                exp_hit = (i >= 3 && (i - 3) % 3 == 0);
                #1 chk($sformatf("S%0d aout", i), {7'd0, aout2}, {7'd0, exp_hit});
                if (exp_hit) hits++;
                @(posedge clk);
                #1 chk($sformatf("S%0d count", i), {6'd0, cnt2},
                       8'((hits > 3) ? 3 : hits));
            end
            iv2 = L;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
